// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin arbiter sharing one AES core between two requesters.
// Build option: define AES_ARB_TIMEOUT_EN to abort a stuck core job with resp*_err=1.
module aes_core_arbiter #(
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_state,
    input  logic [DATA_W-1:0] req0_key,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_data,
    output logic              resp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_state,
    input  logic [DATA_W-1:0] req1_key,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_data,
    output logic              resp1_err,
    output logic              core_start,
    output logic [DATA_W-1:0] core_state,
    output logic [DATA_W-1:0] core_key,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              owner;
    logic              grant;
    logic              accept;
    logic              xfer;
    logic              timeout_hit;
    logic [DATA_W-1:0] cap_state;
    logic [DATA_W-1:0] cap_key;
    logic [DATA_W-1:0] result;

    // The watchdog counter must be able to reach TIMEOUT_CYC.
    if (TIMEOUT_CYC >= (1 << CNT_W)) begin : g_cnt_w_too_small
    end

    always_comb begin
        grant  = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;
        accept = (state == IDLE) && (req0_valid || req1_valid);
        xfer   = (state == RESP) && (owner ? resp1_ready : resp0_ready);
    end

`ifdef AES_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // A core_done landing on the last WAIT cycle beats the abort.
    assign timeout_hit = (state == WAIT) && !core_done &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign resp0_err = resp0_valid & err_q;
    assign resp1_err = resp1_valid & err_q;
`else
    assign timeout_hit = 1'b0;
    assign resp0_err   = 1'b0;
    assign resp1_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (core_done || timeout_hit) state_nxt = RESP;
            RESP:    if (xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cap_state  <= '0;
            cap_key    <= '0;
            result     <= '0;
        end else begin
            if (accept) begin
                owner     <= grant;
                cap_state <= grant ? req1_state : req0_state;
                cap_key   <= grant ? req1_key : req0_key;
            end
            if (state == WAIT && core_done) begin
                result <= core_out;
            end else if (timeout_hit) begin
                result <= '0;
            end
            if (xfer) begin
                last_grant <= owner;
            end
        end
    end

    // Ready is gated by rst so nothing handshakes while reset is held.
    always_comb begin
        busy        = (state != IDLE);
        core_start  = (state == ISSUE);
        req0_ready  = rst && accept && !grant;
        req1_ready  = rst && accept && grant;
        core_state  = '0;
        core_key    = '0;
        if (state == ISSUE || state == WAIT) begin
            core_state = cap_state;
            core_key   = cap_key;
        end
        resp0_valid = (state == RESP) && !owner;
        resp1_valid = (state == RESP) && owner;
        resp0_data  = resp0_valid ? result : '0;
        resp1_data  = resp1_valid ? result : '0;
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: grant table, directed corner sequences and random
// traffic checked every cycle against a transaction-timing reference model.
module tb_aes_core_arbiter;

    localparam int DATA_W      = 128;
    localparam int TIMEOUT_CYC = 64;
    localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_err;
    logic              req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_err;
    logic [DATA_W-1:0] req0_state, req0_key, resp0_data;
    logic [DATA_W-1:0] req1_state, req1_key, resp1_data;
    logic              core_start, core_done, busy;
    logic [DATA_W-1:0] core_state, core_key, core_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int job_lat = 10;

    logic         model_done = 1'b0;
    logic         stray_done = 1'b0;
    logic [127:0] model_data = '0;
    logic [127:0] stray_data = '0;
    int           pend_cnt   = 0;
    logic [127:0] pend_data  = '0;

    logic         m_busy  = 1'b0;
    logic         m_owner = 1'b0;
    logic         m_last  = 1'b1;
    logic         m_err   = 1'b0;
    int           m_tacc  = 0;
    int           m_lat   = 1;
    int           m_eff   = 1;
    logic [127:0] m_state = '0;
    logic [127:0] m_key   = '0;
    logic [127:0] m_res   = '0;
    int           grant_log[$];

    typedef struct {
        logic v0;
        logic v1;
        logic r0;
        logic r1;
    } vec_t;

    assign core_done = model_done | stray_done;
    assign core_out  = model_done ? model_data : stray_data;

    always #5 clk = ~clk;

    aes_core_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_state(req0_state), .req0_key(req0_key),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data), .resp0_err(resp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_state(req1_state), .req1_key(req1_key),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data), .resp1_err(resp1_err),
        .core_start(core_start), .core_state(core_state), .core_key(core_key),
        .core_done(core_done), .core_out(core_out), .busy(busy)
    );

    function automatic logic [127:0] core_fn(input logic [127:0] s, input logic [127:0] k);
        if (s == PT && k == KEY) return CT;
        return s ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_1234_5678_9abc_def0;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Expected outputs from job timestamps: start at accept+1, result at accept+2+latency.
    task automatic model_expect(output logic r0, output logic r1, output logic bz, output logic st,
                                output logic v0, output logic v1,
                                output logic [127:0] cs, output logic [127:0] ck);
        r0 = 0; r1 = 0; bz = m_busy; st = 0; v0 = 0; v1 = 0; cs = '0; ck = '0;
        if (m_busy) begin
            st = (cyc == m_tacc + 1);
            if (cyc >= m_tacc + 1 && cyc <= m_tacc + 1 + m_eff) begin
                cs = m_state;
                ck = m_key;
            end
            if (cyc >= m_tacc + 2 + m_eff) begin
                v0 = !m_owner;
                v1 = m_owner;
            end
        end else if (req0_valid && req1_valid) begin
            r0 = m_last;
            r1 = !m_last;
        end else begin
            r0 = req0_valid;
            r1 = req1_valid;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Simple core: answers m_lat cycles after the start pulse, even across arbiter resets.
    always @(posedge clk) begin
        if (core_start) begin
            pend_cnt  = m_lat;
            pend_data = core_fn(core_state, core_key);
        end
        #1;
        model_done = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                model_done = 1'b1;
                model_data = pend_data;
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        logic e_r0, e_r1, e_bz, e_st, e_v0, e_v1;
        logic [127:0] e_cs, e_ck;
        if (!rst) begin
            m_busy = 1'b0;
            m_last = 1'b1;
        end else begin
            if (req0_valid && req0_ready) grant_log.push_back(0);
            if (req1_valid && req1_ready) grant_log.push_back(1);
            model_expect(e_r0, e_r1, e_bz, e_st, e_v0, e_v1, e_cs, e_ck);
            if (m_busy) begin
                if ((e_v0 && resp0_ready) || (e_v1 && resp1_ready)) begin
                    m_busy = 1'b0;
                    m_last = m_owner;
                end
            end else if (e_r0 || e_r1) begin
                m_busy  = 1'b1;
                m_owner = e_r1;
                m_tacc  = cyc;
                m_state = e_r1 ? req1_state : req0_state;
                m_key   = e_r1 ? req1_key : req0_key;
                m_lat   = job_lat;
                m_eff   = job_lat;
                m_err   = 1'b0;
                m_res   = core_fn(m_state, m_key);
`ifdef AES_ARB_TIMEOUT_EN
                if (job_lat > TIMEOUT_CYC) begin
                    m_eff = TIMEOUT_CYC;
                    m_err = 1'b1;
                    m_res = '0;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        logic e_r0, e_r1, e_bz, e_st, e_v0, e_v1;
        logic [127:0] e_cs, e_ck;
        if (!rst) begin
            check_output("rst_outputs", {req0_ready, req1_ready, busy, core_start, resp0_valid,
                                         resp1_valid, resp0_err, resp1_err}, '0);
            check_output("rst_data", resp0_data | resp1_data | core_state | core_key, '0);
        end else begin
            model_expect(e_r0, e_r1, e_bz, e_st, e_v0, e_v1, e_cs, e_ck);
            check_output("req0_ready", req0_ready, e_r0);
            check_output("req1_ready", req1_ready, e_r1);
            check_output("busy", busy, e_bz);
            check_output("core_start", core_start, e_st);
            check_output("core_state", core_state, e_cs);
            check_output("core_key", core_key, e_ck);
            check_output("resp0_valid", resp0_valid, e_v0);
            check_output("resp1_valid", resp1_valid, e_v1);
            check_output("resp0_err", resp0_err, e_v0 & m_err);
            check_output("resp1_err", resp1_err, e_v1 & m_err);
            if (e_v0) check_output("resp0_data", resp0_data, m_res);
            if (e_v1) check_output("resp1_data", resp1_data, m_res);
        end
    end

    task automatic apply_stimulus(input vec_t v, input int idx);
        @(posedge clk); #1;
        req0_valid = v.v0; req0_state = rand128(); req0_key = rand128();
        req1_valid = v.v1; req1_state = rand128(); req1_key = rand128();
        @(negedge clk);
        check_output($sformatf("tbl%0d_ready0", idx), req0_ready, v.r0);
        check_output($sformatf("tbl%0d_ready1", idx), req1_ready, v.r1);
        #1;
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic wait_ready(input logic who, output int t);
        logic got = 0;
        t = -1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (who ? req1_ready : req0_ready) begin
                got = 1;
                t = cyc;
            end
        end
        check_output("handshake_seen", got, 1'b1);
    endtask

    task automatic wait_idle(input int bound);
        logic idle = 0;
        for (int i = 0; i < bound && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
        end
        check_output("idle_reached", idle, 1'b1);
    endtask

    task automatic run_job(input logic who, input int lat, input logic [127:0] st, input logic [127:0] k,
                           output int t, output int n_start, output int t_start, output int t_resp,
                           output logic [127:0] data, output logic err, output logic other);
        logic got = 0;
        int   bound;
        n_start = 0; t_start = -1; t_resp = -1; data = '0; err = 0; other = 0;
        job_lat = lat;
        bound = ((lat > 80) ? 80 : lat) + 16;
        @(posedge clk); #1;
        if (!who) begin
            req0_valid = 1; req0_state = st; req0_key = k; resp0_ready = 1;
        end else begin
            req1_valid = 1; req1_state = st; req1_key = k; resp1_ready = 1;
        end
        wait_ready(who, t);
        @(posedge clk); #1;
        if (!who) req0_valid = 0; else req1_valid = 0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if (core_start) begin
                n_start++;
                t_start = cyc;
            end
            if (who ? resp0_valid : resp1_valid) other = 1;
            if (who ? resp1_valid : resp0_valid) begin
                got    = 1;
                t_resp = cyc;
                data   = who ? resp1_data : resp0_data;
                err    = who ? resp1_err : resp0_err;
            end
        end
        check_output("resp_seen", got, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t         tbl[4];
        int           t, n_start, t_start, t_resp;
        logic [127:0] data, st, k;
        logic         err, other, seen;

        tbl[0] = '{v0: 0, v1: 0, r0: 0, r1: 0};
        tbl[1] = '{v0: 1, v1: 0, r0: 1, r1: 0};
        tbl[2] = '{v0: 0, v1: 1, r0: 0, r1: 1};
        tbl[3] = '{v0: 1, v1: 1, r0: 1, r1: 0};

        req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
        req0_state = '0; req0_key = '0; req1_state = '0; req1_key = '0;
        #2 rst = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_busy", busy, 1'b0);
        check_output("reset_resp_data", resp0_data | resp1_data, '0);
        @(posedge clk); #1 rst = 1;

        for (int i = 0; i < 4; i++) apply_stimulus(tbl[i], i);

        run_job(0, 10, PT, KEY, t, n_start, t_start, t_resp, data, err, other);
        check_output("single_start_count", n_start, 1);
        check_output("single_start_cycle", t_start, t + 1);
        check_output("single_resp_cycle", t_resp, t + 12);
        check_output("single_resp_data", data, CT);
        check_output("single_resp1_quiet", other, 1'b0);
        check_output("single_err", err, 1'b0);

        @(posedge clk); #1 stray_done = 1; stray_data = rand128();
        @(negedge clk);
        check_output("stray_idle_busy", busy, 1'b0);
        check_output("stray_idle_resp", {resp0_valid, resp1_valid}, '0);
        @(posedge clk); #1 stray_done = 0;
        @(negedge clk);
        check_output("stray_idle_busy_after", busy, 1'b0);

        // Backpressure on requester 0 with requester 1 waiting and a stray done in RESP.
        st = rand128(); k = rand128();
        job_lat = 4;
        @(posedge clk); #1;
        req0_valid = 1; req0_state = st; req0_key = k; resp0_ready = 0;
        wait_ready(0, t);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 1; req1_state = rand128(); req1_key = rand128(); resp1_ready = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = resp0_valid;
        end
        check_output("bp_resp_seen", seen, 1'b1);
        for (int i = 0; i < 20; i++) begin
            check_output($sformatf("bp%0d_valid", i), resp0_valid, 1'b1);
            check_output($sformatf("bp%0d_data", i), resp0_data, core_fn(st, k));
            check_output($sformatf("bp%0d_req1_ready", i), req1_ready, 1'b0);
            @(posedge clk); #1;
            stray_done = (i == 5);
            stray_data = rand128();
            if (i == 19) resp0_ready = 1;
            @(negedge clk);
        end
        wait_ready(1, t);
        @(posedge clk); #1 req1_valid = 0;
        wait_idle(30);

        // Both requesters valid straight out of reset.
        @(posedge clk); #1;
        rst = 0;
        req0_valid = 1; req1_valid = 1; resp0_ready = 1; resp1_ready = 1;
        req0_state = rand128(); req0_key = rand128();
        req1_state = rand128(); req1_key = rand128();
        job_lat = 3;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        grant_log.delete();
        for (int i = 0; i < 200 && grant_log.size() < 4; i++) @(posedge clk);
        #1 req0_valid = 0; req1_valid = 0;
        check_output("fair_count", grant_log.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check_output($sformatf("fair_grant%0d", i), grant_log[i], i % 2);
        wait_idle(30);

        // Reset while the core is busy; its late done must be ignored.
        job_lat = 30;
        @(posedge clk); #1;
        req0_valid = 1; req0_state = rand128(); req0_key = rand128();
        wait_ready(0, t);
        @(posedge clk); #1 req0_valid = 0;
        repeat (5) @(posedge clk);
        #1 rst = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        check_output("midrst_busy", busy, 1'b0);
        check_output("midrst_core", {core_start, core_state}, '0);
        seen = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (resp0_valid || resp1_valid || busy) seen = 1;
        end
        check_output("midrst_late_done_ignored", seen, 1'b0);
        st = rand128(); k = rand128();
        run_job(1, 5, st, k, t, n_start, t_start, t_resp, data, err, other);
        check_output("midrst_req1_data", data, core_fn(st, k));
        check_output("midrst_req1_latency", t_resp, t + 7);

`ifdef AES_ARB_TIMEOUT_EN
        run_job(0, 100000, rand128(), rand128(), t, n_start, t_start, t_resp, data, err, other);
        check_output("to_resp_cycle", t_resp, t + 2 + TIMEOUT_CYC);
        check_output("to_data", data, '0);
        check_output("to_err", err, 1'b1);
        st = rand128(); k = rand128();
        run_job(0, TIMEOUT_CYC, st, k, t, n_start, t_start, t_resp, data, err, other);
        check_output("to_edge_cycle", t_resp, t + 2 + TIMEOUT_CYC);
        check_output("to_edge_data", data, core_fn(st, k));
        check_output("to_edge_err", err, 1'b0);
        run_job(0, TIMEOUT_CYC + 1, rand128(), rand128(), t, n_start, t_start, t_resp, data, err, other);
        check_output("to_late_err", err, 1'b1);
        wait_idle(10);
`endif

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            req0_valid  = ($urandom % 3) != 0;
            req1_valid  = ($urandom % 3) != 0;
            req0_state  = rand128(); req0_key = rand128();
            req1_state  = rand128(); req1_key = rand128();
            resp0_ready = ($urandom % 2) != 0;
            resp1_ready = ($urandom % 2) != 0;
            job_lat     = $urandom_range(1, 12);
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0; resp0_ready = 1; resp1_ready = 1;
        wait_idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one AES encryption core between two requesters (req0, req1) using round-robin arbitration.
- Accepts a plaintext/key pair from the granted requester and pulses the core's start.
- Waits for the core's done, then returns the ciphertext to the same requester over a valid/ready response channel.
- Sits between the host-side request logic and the AES core top.

Parameters:
- DATA_W, 128, width of state, key and result buses.
- TIMEOUT_CYC, 64, max cycles in WAIT before abort (used only with the optional feature).
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  arbiter accepts the req0 job this cycle.
- req0_state  in  DATA_W  requester 0 plaintext.
- req0_key  in  DATA_W  requester 0 key.
- resp0_valid  out  1  result for requester 0 is available.
- resp0_ready  in  1  requester 0 takes the result.
- resp0_data  out  DATA_W  ciphertext for requester 0.
- resp0_err  out  1  timeout flag for requester 0; tied 0 without the optional feature.
- req1_valid, req1_ready, req1_state, req1_key, resp1_valid, resp1_ready, resp1_data, resp1_err: same as the req0/resp0 ports, for requester 1.
- core_start  out  1  one-cycle start pulse to the AES core.
- core_state  out  DATA_W  plaintext to the core; held stable from start until done.
- core_key  out  DATA_W  key to the core; held stable from start until done.
- core_done  in  1  core result valid (one-cycle pulse).
- core_out  in  DATA_W  core ciphertext.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE and the last-grant pointer is set to 1, so req0 wins the first tie.
  - Captured state, key and result registers clear to 0.
  - All outputs are 0 during and after reset, including busy, core_start, resp*_valid, resp*_err and resp*_data.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant selection is combinational. Only one valid: grant that requester. Both valid: grant the one that is not the last-grant pointer.
  - reqN_ready is high only in IDLE, only for the granted N, and only while reqN_valid=1. The handshake completes in that cycle.
  - On the handshake: capture reqN_state and reqN_key, record the owner, go to ISSUE.
- ISSUE: core_start=1 for exactly one cycle, then go to WAIT.
- core_state and core_key drive the captured registers in ISSUE and WAIT; they are 0 otherwise.
- WAIT:
  - On core_done=1: capture core_out into the result register, go to RESP.
  - core_done seen in IDLE, ISSUE or RESP is ignored.
- RESP:
  - respN_valid=1 for the owner only, with respN_data = captured result.
  - Data stays stable until respN_ready=1; that cycle completes the transfer.
  - After the transfer: last-grant pointer ← owner, go to IDLE.
  - The non-owner's resp*_valid stays 0.
- Latency: handshake at cycle t → core_start at t+1. Core done at t+1+L → resp_valid at t+2+L.
- Back-to-back: a new job is accepted no earlier than the cycle after the RESP transfer; there is one job in flight at a time.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- Reset mid-operation: the in-flight job is dropped and no response is ever produced for it.
- Requester deasserting valid without a handshake: permitted; no side effect.

Optional Feature:
- Macro: AES_ARB_TIMEOUT_EN.
- Defined:
  - A CNT_W counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC with no core_done: go to RESP with respN_data=0 and respN_err=1 (valid with data).
  - A core_done arriving in the same cycle as the timeout wins: normal result, err=0.
  - Late core_done after the abort is ignored.
- Not defined: no counter, resp*_err tied 0, WAIT waits indefinitely.

Test Plan:
- Reset then single job: req0 with state=3243f6a8885a308d313198a2e0370734 and key=2b7e151628aed2a6abf7158809cf4f3c; core model with L=10 returns 3925841d02dc09fbdc118597196a0b32. Required:
  - core_start exactly once, at t+1.
  - resp0_valid at t+12 with that data; resp1_valid stays 0.
- Contention: req0 and req1 both valid from reset. Required: grant order 0,1,0,1 over 4 jobs; each response is routed to its own requester.
- Response backpressure: resp0_ready held low for 20 cycles. Required:
  - resp0_valid and resp0_data stay stable for all 20 cycles.
  - req1_ready stays 0 until the transfer completes.
- Stray done: core_done pulsed in IDLE and in RESP. Required: no state change and no response.
- Reset mid-WAIT: rst=0 for 2 cycles while the core is running, then released. Required:
  - busy=0 and all outputs 0 after reset.
  - A later core_done is ignored.
  - The next req1 job completes normally.
- With AES_ARB_TIMEOUT_EN and TIMEOUT_CYC=64, core never done. Required:
  - resp0_valid at cycle 64 of WAIT with resp0_data=0 and resp0_err=1.
  - A core_done on cycle 64 itself gives err=0 and the core data instead.
